// File: rtl/imm_encoder_loader_pkg.sv
// Shared definitions for the immediate encoder/loader: IMM_SRC format codes
// (common with the decode stage) and the loader FSM state encoding.
package imm_encoder_loader_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // True when v is representable as a bits-wide two's-complement value,
  // i.e. every bit from bits-1 upward equals the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] mask;
    mask = ~((32'd1 << (bits - 1)) - 32'd1);
    return ((v & mask) == 32'd0) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: places imm into the RISC-V I/U/S/J/B bit
// positions of base_inst and flags immediates the format cannot represent.
module imm_pack
  import imm_encoder_loader_pkg::*;
(
  input  logic [31:0] base_inst,
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  output logic [31:0] word,
  output logic        range_err
);

  logic [31:0] clear_mask;
  logic [31:0] fields;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    clear_mask = 32'h0000_0000;
    fields     = 32'h0000_0000;
    range_err  = 1'b1;
    case (imm_src)
      IMM_I: begin
        clear_mask = 32'hFFF0_0000;
        fields     = {imm[11:0], 20'b0};
        range_err  = !fits_signed(imm, 12);
      end
      IMM_U: begin
        clear_mask = 32'hFFFF_F000;
        fields     = {imm[31:12], 12'b0};
        range_err  = (imm[11:0] != 12'd0);
      end
      IMM_S: begin
        clear_mask = 32'hFE00_0F80;
        fields     = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err  = !fits_signed(imm, 12);
      end
      IMM_J: begin
        clear_mask = 32'hFFFF_F000;
        fields     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err  = imm[0] || !fits_signed(imm, 21);
      end
      IMM_B: begin
        clear_mask = 32'hFE00_0F80;
        fields     = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err  = imm[0] || !fits_signed(imm, 13);
      end
      default: begin
        clear_mask = 32'h0000_0000;
        fields     = 32'h0000_0000;
        range_err  = 1'b1;
      end
    endcase
  end

  assign word = (base_inst & ~clear_mask) | fields;

endmodule

// File: rtl/imm_encoder_loader.sv
// Instruction-word assembler and loader: packs immediates into base
// instructions and streams them into instruction memory from address 0.
module imm_encoder_loader
  import imm_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        imm_src,
  input  logic [31:0]       imm,
  input  logic [31:0]       base_inst,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [31:0]       packed_word;
  logic              packed_err;

  imm_pack u_imm_pack (
    .base_inst (base_inst),
    .imm       (imm),
    .imm_src   (imm_src),
    .word      (packed_word),
    .range_err (packed_err)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          // An error wins over in_last; in_last wins over the memory-full halt.
          if (packed_err)             state_next = ST_HALT;
          else if (in_last)           state_next = ST_IDLE;
          else if (addr == LAST_ADDR) state_next = ST_HALT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state == ST_RUN) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (state != ST_RUN && start) begin
        addr  <= '0;
        count <= '0;
        err   <= 1'b0;
        full  <= 1'b0;
      end else if (accept) begin
        if (packed_err) begin
          err      <= 1'b1;
          err_addr <= addr;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= packed_word;
          count     <= count + (ADDR_W + 1)'(1);
          addr      <= addr + ADDR_W'(1);
          if (addr == LAST_ADDR) full <= 1'b1;
          if (in_last)           done <= 1'b1;
        end
      end
    end
  end

endmodule
